// File: rtl/regfile_np.sv
// Parametrised register file: one write port, NUM_RD read ports, optional
// hardwired-zero entry, same-cycle write bypass and optional registered read.
module regfile_np #(
    parameter int WIDTH    = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*WIDTH-1:0]    rd_data
);

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_np: NUM_RD must be in 1..4");
    end
    if ((2 ** ADDR_W) < NUM_REGS) begin : g_bad_addr_w
        $error("regfile_np: ADDR_W too narrow for NUM_REGS");
    end
    if (ZERO_REG >= NUM_REGS) begin : g_bad_zero_reg
        $error("regfile_np: ZERO_REG must be below NUM_REGS or -1");
    end
    if (NUM_REGS < 2) begin : g_bad_num_regs
        $error("regfile_np: NUM_REGS must be at least 2");
    end

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   NREGS_L  = (ADDR_W + 1)'(NUM_REGS);
    localparam bit                HAS_ZERO = (ZERO_REG >= 0);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(HAS_ZERO ? ZERO_REG : 0);
    localparam bit                USE_BYP  = (BYPASS != 0);

    logic [WIDTH-1:0] mem [NUM_REGS];
    logic [WIDTH-1:0] rd_val [NUM_RD];
    logic             wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < NREGS_L)
                   && !(HAS_ZERO && (wr_addr == ZERO_IDX));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Zero-register and out-of-range squash the bypass as well as the array.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            logic [ADDR_W-1:0] ra;
            ra = rd_addr[p*ADDR_W +: ADDR_W];
            rd_val[p] = '0;
            if (({1'b0, ra} >= NREGS_L) || (HAS_ZERO && (ra == ZERO_IDX))) begin
                rd_val[p] = '0;
            end else if (USE_BYP && wr_en && !reset && (wr_addr == ra)) begin
                rd_val[p] = wr_data;
            end else begin
                rd_val[p] = mem[ra];
            end
        end
    end

    if (READ_REG != 0) begin : g_read_reg
        always_ff @(posedge clk) begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (reset) begin
                    rd_data[p*WIDTH +: WIDTH] <= '0;
                end else begin
                    rd_data[p*WIDTH +: WIDTH] <= rd_val[p];
                end
            end
        end
    end else begin : g_read_comb
        always_comb begin
            rd_data = '0;
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data[p*WIDTH +: WIDTH] = rd_val[p];
            end
        end
    end

endmodule

// File: tb/tb_regfile_np.sv
// Bench for regfile_np: four configurations share one write stream and are
// compared against an array-based reference of the register file contents.
module tb_regfile_np;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [4:0]   ra0, ra1, ra2;
    logic [127:0] rd_a, rd_b, rd_d;
    logic [191:0] rd_c;

    always #5 clk = ~clk;

    // a: defaults (bypass, comb read); b: no bypass, comb read
    regfile_np #(.BYPASS(1), .READ_REG(0)) u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr({ra1, ra0}), .rd_data(rd_a));
    regfile_np #(.BYPASS(0), .READ_REG(0)) u_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr({ra1, ra0}), .rd_data(rd_b));
    // c: 24 entries, no zero reg, 3 ports, registered read
    regfile_np #(.NUM_REGS(24), .ADDR_W(5), .ZERO_REG(-1), .NUM_RD(3),
                 .BYPASS(1), .READ_REG(1)) u_c (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr({ra2, ra1, ra0}), .rd_data(rd_c));
    // d: no bypass, registered read
    regfile_np #(.BYPASS(0), .READ_REG(1)) u_d (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr({ra1, ra0}), .rd_data(rd_d));

    logic [63:0] m32 [32];
    logic [63:0] m24 [24];
    logic [63:0] exp_q [$];
    int          n_vec = 0;
    int          n_miscmp = 0;
    bit          chk_on = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural read rule for one port of a given configuration.
    function automatic logic [63:0] model_rd(input int nregs, input int zero, input bit byp,
                                             input int addr, input logic [63:0] stored,
                                             input bit rst, input bit we, input int wa,
                                             input logic [63:0] wd);
        if (addr >= nregs || addr == zero) return 64'd0;
        if (byp && we && !rst && wa == addr) return wd;
        return stored;
    endfunction

    function automatic logic [63:0] s24(input int addr);
        return (addr < 24) ? m24[addr] : 64'd0;
    endfunction

    task automatic step(input bit rst, input bit we, input int wa, input logic [63:0] wd,
                        input int r0, input int r1, input int r2);
        logic [63:0] e;
        reset   = rst;
        wr_en   = we;
        wr_addr = wa[4:0];
        wr_data = wd;
        ra0     = r0[4:0];
        ra1     = r1[4:0];
        ra2     = r2[4:0];
        #1;
        if (chk_on) begin
            check("a_rd0", rd_a[63:0],   model_rd(32, 31, 1'b1, r0, m32[r0], rst, we, wa, wd));
            check("a_rd1", rd_a[127:64], model_rd(32, 31, 1'b1, r1, m32[r1], rst, we, wa, wd));
            check("b_rd0", rd_b[63:0],   model_rd(32, 31, 1'b0, r0, m32[r0], rst, we, wa, wd));
            check("b_rd1", rd_b[127:64], model_rd(32, 31, 1'b0, r1, m32[r1], rst, we, wa, wd));
            if (exp_q.size() >= 5) begin
                check("c_rd0", rd_c[63:0],    exp_q.pop_front());
                check("c_rd1", rd_c[127:64],  exp_q.pop_front());
                check("c_rd2", rd_c[191:128], exp_q.pop_front());
                check("d_rd0", rd_d[63:0],    exp_q.pop_front());
                check("d_rd1", rd_d[127:64],  exp_q.pop_front());
            end
            e = rst ? 64'd0 : model_rd(24, -1, 1'b1, r0, s24(r0), rst, we, wa, wd);
            exp_q.push_back(e);
            e = rst ? 64'd0 : model_rd(24, -1, 1'b1, r1, s24(r1), rst, we, wa, wd);
            exp_q.push_back(e);
            e = rst ? 64'd0 : model_rd(24, -1, 1'b1, r2, s24(r2), rst, we, wa, wd);
            exp_q.push_back(e);
            e = rst ? 64'd0 : model_rd(32, 31, 1'b0, r0, m32[r0], rst, we, wa, wd);
            exp_q.push_back(e);
            e = rst ? 64'd0 : model_rd(32, 31, 1'b0, r1, m32[r1], rst, we, wa, wd);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m32[i] = 64'd0;
            for (int i = 0; i < 24; i++) m24[i] = 64'd0;
        end else if (we) begin
            if (wa < 32 && wa != 31) m32[wa] = wd;
            if (wa < 24) m24[wa] = wd;
        end
        @(negedge clk);
    endtask

    initial begin
        int r;
        // bring-up reset: DUT contents are unknown before this edge
        step(1'b1, 1'b0, 0, 64'd0, 0, 0, 0);
        chk_on = 1'b1;
        step(1'b1, 1'b0, 0, 64'd0, 0, 1, 2);

        // fill everything, then a single reset cycle clears it
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, i, 64'hDEADBEEF_CAFEF00D, i, 31 - i, i);
        step(1'b1, 1'b0, 0, 64'd0, 4, 9, 17);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 0, 64'd0, i, 31 - i, (i + 7) % 32);

        // basic write/read pattern
        for (int i = 0; i < 31; i++) step(1'b0, 1'b1, i, 64'h0101010101010101 * i, 31, 0, i);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 0, 64'd0, i, (30 - i) & 31, i);

        // zero register: write attempt, then read back on both ports
        step(1'b0, 1'b1, 31, {64{1'b1}}, 31, 31, 31);
        step(1'b0, 1'b0, 0, 64'd0, 31, 31, 31);

        // bypass vs no-bypass on entry 5
        step(1'b0, 1'b1, 5, 64'h11, 0, 1, 2);
        step(1'b0, 1'b1, 5, 64'h22, 5, 5, 5);
        step(1'b0, 1'b0, 0, 64'd0, 5, 5, 5);
        step(1'b0, 1'b0, 0, 64'd0, 5, 5, 5);

        // reset collides with a write to entry 3
        step(1'b0, 1'b1, 3, 64'h99, 3, 3, 3);
        step(1'b1, 1'b1, 3, 64'h55, 3, 3, 3);
        step(1'b0, 1'b0, 0, 64'd0, 3, 3, 3);
        step(1'b0, 1'b0, 0, 64'd0, 3, 3, 3);

        // 24-entry config: out-of-range write, index 0, same index on 3 ports
        step(1'b0, 1'b1, 27, 64'hABCD, 27, 27, 27);
        step(1'b0, 1'b0, 0, 64'd0, 27, 27, 27);
        step(1'b0, 1'b1, 0, 64'h7, 1, 2, 3);
        step(1'b0, 1'b1, 10, 64'h1234_5678_9ABC_DEF0, 0, 0, 0);
        step(1'b0, 1'b0, 0, 64'd0, 10, 10, 10);
        step(1'b0, 1'b0, 0, 64'd0, 10, 10, 10);

        // randomized traffic, reads biased towards the write address
        for (int n = 0; n < 400; n++) begin
            bit rst_b, we_b;
            int wa, r0, r1, r2;
            rst_b = ($urandom_range(0, 59) == 0);
            we_b  = ($urandom_range(0, 3) != 0);
            wa    = $urandom_range(0, 31);
            r     = $urandom_range(0, 3);
            r0    = (r == 0) ? wa : $urandom_range(0, 31);
            r1    = (r == 1) ? wa : $urandom_range(0, 31);
            r2    = (r == 2) ? r0 : $urandom_range(0, 31);
            step(rst_b, we_b, wa, {$urandom, $urandom}, r0, r1, r2);
        end
        step(1'b0, 1'b0, 0, 64'd0, 0, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
